// File: rtl/flappy_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : flappy_game_ctrl
//  Purpose  : Flappy-bird style game controller. Frame-rate kinematics for the
//             bird and a single scrolling pipe, collision and score logic, and
//             the game state machine (idle / play / fall / done).
//  Options  : FLAPPY_LFSR_GAP_EN - when defined, each new pipe gap centre is
//             drawn from a free-running 10-bit LFSR (range 120..375); when
//             undefined the gap centre is the constant 240.
//  Revision : 1.0 - initial release
// ============================================================================
module flappy_game_ctrl #(
  parameter int BIRD_X     = 160,
  parameter int BIRD_R     = 8,
  parameter int PIPE_W     = 40,
  parameter int GAP_H      = 120,
  parameter int FLOOR_Y    = 470,
  parameter int FLAP_V     = 8,
  parameter int MAX_FALL   = 10,
  parameter int PIPE_SPEED = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       flap,
  output logic [1:0] state,
  output logic [9:0] bird_y,
  output logic [9:0] pipe_x,
  output logic [9:0] gap_y,
  output logic [3:0] score,
  output logic       pass_pulse
);

  typedef enum logic [1:0] {
    QI    = 2'b00,
    QPLAY = 2'b01,
    QFALL = 2'b10,
    QDONE = 2'b11
  } state_t;

  // Geometry constants, widened so sums such as pipe_x+PIPE_W never wrap.
  localparam logic        [11:0] c_bird_left  = 12'(BIRD_X - BIRD_R);
  localparam logic        [11:0] c_bird_right = 12'(BIRD_X + BIRD_R);
  localparam logic        [11:0] c_bird_r     = 12'(BIRD_R);
  localparam logic        [11:0] c_pipe_w     = 12'(PIPE_W);
  localparam logic        [11:0] c_half_gap   = 12'(GAP_H / 2);
  localparam logic signed [10:0] c_floor_s    = 11'(FLOOR_Y);
  localparam logic        [9:0]  c_floor      = 10'(FLOOR_Y);
  localparam logic signed [5:0]  c_max_fall   = 6'(MAX_FALL);
  localparam logic signed [5:0]  c_flap_neg   = 6'(-FLAP_V);
  localparam logic        [9:0]  c_pipe_speed = 10'(PIPE_SPEED);
  localparam logic        [9:0]  c_pipe_start = 10'd639;
  localparam logic        [9:0]  c_start_y    = 10'd240;

  state_t             r_state;
  logic        [9:0]  r_bird_y;
  logic        [9:0]  r_pipe_x;
  logic        [9:0]  r_gap_y;
  logic        [3:0]  r_score;
  logic               r_pass_pulse;
  logic signed [5:0]  r_vel;
  logic               r_flap_d;
  logic               r_flap_lat;

  logic               w_flap_edge;
  logic signed [5:0]  w_vel_inc;
  logic signed [5:0]  w_vel_apply;
  logic signed [10:0] w_y_sum;
  logic        [9:0]  w_y_next;
  logic               w_at_floor;
  logic               w_pipe_wrap;
  logic        [9:0]  w_pipe_next;
  logic        [9:0]  w_gap_new;
  logic               w_edge_old;
  logic               w_edge_new;
  logic               w_score_inc;
  logic               w_x_hit;
  logic               w_y_hit;
  logic               w_collide;

  assign state      = r_state;
  assign bird_y     = r_bird_y;
  assign pipe_x     = r_pipe_x;
  assign gap_y      = r_gap_y;
  assign score      = r_score;
  assign pass_pulse = r_pass_pulse;

  assign w_flap_edge = flap & ~r_flap_d;

  // Gravity with a terminal-velocity clamp; a pending flap overrides it only
  // while playing, so flaps pressed during the fall have no effect.
  assign w_vel_inc   = (r_vel >= c_max_fall) ? c_max_fall : (r_vel + 6'sd1);
  assign w_vel_apply = ((r_state == QPLAY) && r_flap_lat) ? c_flap_neg : w_vel_inc;

  // Position update in signed 11-bit, then clamped into 0..FLOOR_Y.
  assign w_y_sum    = $signed({1'b0, r_bird_y}) + $signed({{5{w_vel_apply[5]}}, w_vel_apply});
  assign w_at_floor = !w_y_sum[10] && (w_y_sum >= c_floor_s);
  assign w_y_next   = w_y_sum[10] ? 10'd0 : (w_at_floor ? c_floor : w_y_sum[9:0]);

  assign w_pipe_wrap = (r_pipe_x < c_pipe_speed);
  assign w_pipe_next = w_pipe_wrap ? c_pipe_start : (r_pipe_x - c_pipe_speed);

  // The pipe's trailing edge crossing the bird's left edge marks a pass.
  assign w_edge_old  = (({2'b0, r_pipe_x} + c_pipe_w) >= c_bird_left);
  assign w_edge_new  = (({2'b0, w_pipe_next} + c_pipe_w) < c_bird_left);
  assign w_score_inc = w_edge_old && w_edge_new && (r_score < 4'd10);

  // Collision on the current frame; the vertical test is rearranged so both
  // sides stay non-negative (bird_y-R < gap_y-H/2  <=>  bird_y+H/2 < gap_y+R).
  assign w_x_hit   = ({2'b0, r_pipe_x} <= c_bird_right) && w_edge_old;
  assign w_y_hit   = (({2'b0, r_bird_y} + c_half_gap) < ({2'b0, r_gap_y} + c_bird_r)) ||
                     (({2'b0, r_bird_y} + c_bird_r) > ({2'b0, r_gap_y} + c_half_gap));
  assign w_collide = w_x_hit && w_y_hit;

`ifdef FLAPPY_LFSR_GAP_EN
  logic [9:0] r_lfsr;

  // Maximal-length 10-bit LFSR (x^10 + x^7 + 1), stepped once per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 10'h1A5;
    end else if (tick) begin
      r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end
  end

  assign w_gap_new = 10'd120 + {2'b00, r_lfsr[7:0]};
`else
  assign w_gap_new = c_start_y;
`endif

  // Flap rising edges are held until the next frame tick consumes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flap_d   <= 1'b0;
      r_flap_lat <= 1'b0;
    end else begin
      r_flap_d <= flap;
      if (tick) begin
        r_flap_lat <= w_flap_edge;
      end else if (w_flap_edge) begin
        r_flap_lat <= 1'b1;
      end
    end
  end

  // Game state machine and per-frame kinematics, all outputs registered.
  always_ff @(posedge clk) begin
    r_pass_pulse <= 1'b0;
    if (reset) begin
      r_state  <= QI;
      r_bird_y <= c_start_y;
      r_vel    <= '0;
      r_pipe_x <= c_pipe_start;
      r_gap_y  <= c_start_y;
      r_score  <= '0;
    end else if (tick) begin
      case (r_state)
        QI: begin
          if (start) begin
            r_state  <= QPLAY;
            r_bird_y <= c_start_y;
            r_vel    <= '0;
            r_pipe_x <= c_pipe_start;
            r_score  <= '0;
          end
        end
        QPLAY: begin
          r_vel    <= w_vel_apply;
          r_bird_y <= w_y_next;
          r_pipe_x <= w_pipe_next;
          if (w_pipe_wrap) begin
            r_gap_y <= w_gap_new;
          end
          if (w_score_inc) begin
            r_score      <= r_score + 4'd1;
            r_pass_pulse <= 1'b1;
          end
          // Reaching the final score outranks both floor and pipe deaths.
          if (w_score_inc && (r_score == 4'd9)) begin
            r_state <= QDONE;
          end else if (w_at_floor) begin
            r_state <= QDONE;
          end else if (w_collide) begin
            r_state <= QFALL;
          end
        end
        QFALL: begin
          r_vel    <= w_vel_apply;
          r_bird_y <= w_y_next;
          if (w_at_floor) begin
            r_state <= QDONE;
          end
        end
        QDONE: begin
          if (start) begin
            r_state <= QI;
          end
        end
        default: r_state <= QI;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/flappy_game_ctrl.md
FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

Interface
REQ-001 Parameter BIRD_X, default 160: fixed bird column (pixels).
REQ-002 Parameter BIRD_R, default 8: bird half-size (pixels).
REQ-003 Parameter PIPE_W, default 40: pipe width (pixels).
REQ-004 Parameter GAP_H, default 120: vertical gap height (pixels).
REQ-005 Parameter FLOOR_Y, default 470: floor row; the bird is dead at or below it.
REQ-006 Parameter FLAP_V, default 8: upward speed applied on flap (pixels/tick).
REQ-007 Parameter MAX_FALL, default 10: falling speed clamp (pixels/tick).
REQ-008 Parameter PIPE_SPEED, default 2: pipe leftward step (pixels/tick).
REQ-009 Port clk, input, 1: single clock, the same one driving hvsync_generator; all logic on its rising edge.
REQ-010 Port reset, input, 1: synchronous, active-high reset.
REQ-011 Port tick, input, 1: one-cycle frame-update enable, asserted once per frame.
REQ-012 Port start, input, 1: level; game start/restart request.
REQ-013 Port flap, input, 1: level from the debounced button.
REQ-014 Port state, output, 2: QI=00, QPLAY=01, QFALL=10, QDONE=11.
REQ-015 Port bird_y, output, 10: bird centre row.
REQ-016 Port pipe_x, output, 10: pipe left edge column, range 0..639.
REQ-017 Port gap_y, output, 10: gap centre row.
REQ-018 Port score, output, 4: pipes passed, range 0..10.
REQ-019 Port pass_pulse, output, 1: one-cycle pulse on each score increment.

Function
REQ-020 The block SHALL update state and kinematics only on cycles with tick=1, except for start and flap edge capture.
REQ-021 A flap rising edge SHALL be latched on any cycle and consumed at the next tick.
REQ-022 From QI, the block SHALL move to QPLAY on the first tick with start=1, loading bird_y=240, vel=0, pipe_x=639, score=0.
REQ-023 In QPLAY, each tick SHALL apply the following:
- vel = latched flap ? -FLAP_V : min(vel+1, MAX_FALL);
- bird_y += vel, saturating at 0;
- pipe_x -= PIPE_SPEED.
REQ-024 vel SHALL be a signed 6-bit value; bird_y arithmetic SHALL be 11-bit signed, then clamped to 0..FLOOR_Y.
REQ-025 When pipe_x < PIPE_SPEED at a tick, the pipe SHALL wrap to pipe_x=639 and load a new gap_y in the same tick.
REQ-026 Score SHALL increment by one, with a single pass_pulse, at the tick where pipe_x+PIPE_W goes from >= BIRD_X-BIRD_R to < BIRD_X-BIRD_R; score saturates at 10.
REQ-027 Pipe collision SHALL be declared when both of the following hold:
- pipe_x <= BIRD_X+BIRD_R and pipe_x+PIPE_W >= BIRD_X-BIRD_R;
- bird_y-BIRD_R < gap_y-GAP_H/2, or bird_y+BIRD_R > gap_y+GAP_H/2.
REQ-028 On a pipe collision, QPLAY SHALL go to QFALL; the pipe then stops and flaps are ignored.
REQ-029 Reaching bird_y >= FLOOR_Y in QPLAY SHALL go directly to QDONE.
REQ-030 In QFALL, gravity SHALL continue until bird_y >= FLOOR_Y, then the block goes to QDONE.
REQ-031 Score reaching 10 SHALL go to QDONE at that tick.
REQ-032 If collision and the score increment occur in the same tick, the score SHALL count and QFALL is taken, unless score becomes 10, in which case QDONE wins.
REQ-033 In QDONE, outputs SHALL hold; a tick with start=1 SHALL go to QI.
REQ-034 Outputs SHALL be registered, and valid on the cycle after the tick that computed them.

Reset
REQ-035 reset=1 SHALL force the following on the next edge, overriding tick and mid-game activity:
- state=QI, bird_y=240, vel=0, pipe_x=639, gap_y=240;
- score=0, pass_pulse=0, flap latch cleared.

Configuration
REQ-036 With FLAPPY_LFSR_GAP_EN defined:
- a 10-bit maximal LFSR (seed 10'h1A5) SHALL free-run on every tick;
- a new gap_y = 120 + (lfsr mod 256), giving range 120..375.
REQ-037 Without FLAPPY_LFSR_GAP_EN, no LFSR SHALL be built and gap_y SHALL be constant 240.

Verification
REQ-038 Sequence: reset, start=1, tick -> state=01, bird_y=240, pipe_x=639, score=0.
REQ-039 Sequence: 5 ticks in QPLAY with no flap -> vel=5 and bird_y=240+1+2+3+4+5=255.
REQ-040 Sequence: flap pulse between ticks with vel=5 -> next tick vel=-8 and bird_y decreases by 8.
REQ-041 Setup: bird held inside the gap while the pipe passes -> exactly one pass_pulse when pipe_x+40 first drops below 152, and score 0->1.
REQ-042 Setup: bird_y=100, gap_y=240 while the pipe overlaps the bird column -> QFALL, then QDONE once bird_y >= 470, with score held.
REQ-043 Sequence: reset asserted in QFALL mid-fall -> next cycle state=00 with all reset values.
